// File: rtl/reg_write_sequencer_pkg.sv
// rtl/reg_write_sequencer_pkg.sv - shared types and constants for the register-write sequencer
package reg_write_sequencer_pkg;

    // Default geometry of the program store
    localparam int DEF_DEPTH   = 16;
    localparam int DEF_IDX_W   = 4;
    localparam int DEF_DELAY_W = 8;

    // prog_word layout: {delay, reg_addr[2:0], reg_data[4:0]}
    localparam int DATA_LSB  = 0;
    localparam int DATA_W    = 5;
    localparam int ADDR_LSB  = 5;
    localparam int ADDR_W    = 3;
    localparam int DELAY_LSB = 8;

    // Signal generator register map
    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_WAVE    = 3'd1;
    localparam logic [2:0] REG_FREQ_LO = 3'd2;
    localparam logic [2:0] REG_FREQ_HI = 3'd3;
    localparam logic [2:0] REG_AMPL    = 3'd4;
    localparam logic [2:0] REG_OFFSET  = 3'd5;
    localparam logic [2:0] REG_PHASE   = 3'd6;
    localparam logic [2:0] REG_DUTY    = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/seq_prog_mem.sv
// rtl/seq_prog_mem.sv - program store with synchronous read, contents not reset
module seq_prog_mem #(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write lands at the edge; read data is registered so it appears one cycle after the address
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/reg_write_sequencer.sv
// rtl/reg_write_sequencer.sv - timed register-write playback with host-priority port arbitration
module reg_write_sequencer
    import reg_write_sequencer_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int IDX_W   = DEF_IDX_W,
    parameter int DELAY_W = DEF_DELAY_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               prog_we,
    input  logic [IDX_W-1:0]   prog_addr,
    input  logic [DELAY_W+7:0] prog_word,
    input  logic               start,
    input  logic               stop,
    input  logic               loop_en,
    input  logic [IDX_W-1:0]   last_idx,
    input  logic               host_we,
    input  logic [2:0]         host_addr,
    input  logic [4:0]         host_data,
    output logic               wr_strobe,
    output logic [2:0]         wr_addr,
    output logic [4:0]         wr_data,
    output logic               busy,
    output logic [IDX_W-1:0]   step_idx,
    output logic               done
);

    localparam int WORD_W = DELAY_W + 8;

    seq_state_t         state;
    logic [IDX_W-1:0]   idx;
    logic [DELAY_W-1:0] cnt;
    logic [WORD_W-1:0]  entry;
    logic               mem_we;
    logic [ADDR_W-1:0]  entry_addr;
    logic [DATA_W-1:0]  entry_data;
    logic [DELAY_W-1:0] entry_delay;

    // The program cannot be modified underneath a running playback
    assign mem_we = prog_we & ~busy;

    assign entry_addr  = entry[ADDR_LSB +: ADDR_W];
    assign entry_data  = entry[DATA_LSB +: DATA_W];
    assign entry_delay = entry[DELAY_LSB +: DELAY_W];
    assign step_idx    = idx;

    // The read address is the current index, so the fetched entry stays stable while ISSUE is held
    seq_prog_mem #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W),
        .WIDTH (WORD_W)
    ) u_prog_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_word),
        .raddr (idx),
        .rdata (entry)
    );

    // Write port: host writes always win; a sequencer write leaves ISSUE only when the port is free and not stopping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else if (host_we) begin
            wr_strobe <= 1'b1;
            wr_addr   <= host_addr;
            wr_data   <= host_data;
        end else if (state == ST_ISSUE && !stop) begin
            wr_strobe <= 1'b1;
            wr_addr   <= entry_addr;
            wr_data   <= entry_data;
        end else begin
            wr_strobe <= 1'b0;
        end
    end

    // Playback FSM: FETCH -> ISSUE -> WAIT per entry, with stop overriding everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            idx   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state <= ST_FETCH;
                            idx   <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    ST_FETCH: begin
                        state <= ST_ISSUE;
                    end
                    ST_ISSUE: begin
                        if (!host_we) begin
                            cnt   <= entry_delay;
                            state <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (cnt == '0) begin
                            if (idx < last_idx) begin
                                idx   <= idx + IDX_W'(1);
                                state <= ST_FETCH;
                            end else if (loop_en) begin
                                idx   <= '0;
                                state <= ST_FETCH;
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else if (tick) begin
                            cnt <= cnt - DELAY_W'(1);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
